branch_predictor: RTL and testbench

- Front-end partner of the execute-stage branch comparator.
- Predicts direction and target for the fetch PC using a BHT of 2-bit saturating counters plus a direct-mapped BTB.
- Consumes the comparator's resolved outcome, trains the tables, and emits a registered mispredict/redirect to fetch.
- Sits between PC generation (lookup side) and execute (resolve side).

---
 rtl/bp_pkg.sv | 44 ++++
 rtl/bp_sat_counter_table.sv | 33 +++
 rtl/branch_predictor.sv | 111 +++++++++++
 tb/tb_branch_predictor.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: 2-bit counter encoding,
// saturating update, and PC index/tag extraction.
package bp_pkg;

  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned PC_MAX_W  = 64;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  localparam bp_cnt_t CNT_RESET = WNT;

  // Saturating step toward the resolved direction.
  function automatic bp_cnt_t sat_update(bp_cnt_t c, logic taken);
    bp_cnt_t n;
    n = c;
    unique case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = CNT_RESET;
    endcase
    return n;
  endfunction

  // Word-aligned table index: pc[idx_w+1:2].
  function automatic logic [PC_MAX_W-1:0] pc_index(logic [PC_MAX_W-1:0] pc,
                                                   int unsigned idx_w);
    return (pc >> 2) & ((PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1));
  endfunction

  // Tag is everything above the index field.
  function automatic logic [PC_MAX_W-1:0] pc_tag(logic [PC_MAX_W-1:0] pc,
                                                 int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// Branch history table: one 2-bit saturating counter per entry, one read port
// and one update port. Reads return pre-update state.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int unsigned ENTRIES = 1 << IDX_W;

  bp_cnt_t cnt [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        cnt[i] <= CNT_RESET;
      end
    end else if (wr_en) begin
      cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
    end
  end

  assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Direction/target predictor: BHT of 2-bit counters plus direct-mapped BTB,
// trained by resolved branches. Define BP_STATS_EN for branch/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            pred_hit,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned TAG_W   = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] res_idx;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       lk_cnt;
  logic             res_mis_c;

  logic             btb_valid [ENTRIES];
  logic [TAG_W-1:0] btb_tag   [ENTRIES];
  logic [XLEN-1:0]  btb_tgt   [ENTRIES];

  assign lk_idx  = IDX_W'(pc_index(PC_MAX_W'(lookup_pc), IDX_W));
  assign lk_tag  = TAG_W'(pc_tag(PC_MAX_W'(lookup_pc), IDX_W));
  assign res_idx = IDX_W'(pc_index(PC_MAX_W'(res_pc), IDX_W));
  assign res_tag = TAG_W'(pc_tag(PC_MAX_W'(res_pc), IDX_W));

  bp_sat_counter_table #(
    .IDX_W (IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lk_idx),
    .rd_cnt   (lk_cnt),
    .wr_en    (res_valid),
    .wr_idx   (res_idx),
    .wr_taken (res_taken)
  );

  // Zero-latency lookup; no bypass from a same-cycle update.
  assign pred_hit    = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && lk_cnt[1];
  assign pred_target = pred_taken ? btb_tgt[lk_idx] : lookup_pc + XLEN'(4);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
      end
    end else if (res_valid && res_taken) begin
      btb_valid[res_idx] <= 1'b1;
    end
  end

  // Tag/target payload needs no reset; valid gates it.
  always_ff @(posedge clk) begin
    if (!rst && res_valid && res_taken) begin
      btb_tag[res_idx] <= res_tag;
      btb_tgt[res_idx] <= res_target;
    end
  end

  assign res_mis_c = (res_taken != res_pred_taken) ||
                     (res_taken && (res_target != res_pred_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= res_valid && res_mis_c;
      if (res_valid) begin
        redirect_pc <= res_taken ? res_target : res_pc + XLEN'(4);
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (res_valid)  stat_branches    <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed steps push expected lookup and
// mispredict responses; a negedge monitor pops and compares.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_hit;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc       (lookup_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_hit        (pred_hit),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        taken;
    logic [31:0] target;
  } lk_exp_t;

  typedef struct {
    logic        mis;
    logic [31:0] redir;
  } mis_exp_t;

  lk_exp_t  lk_q [$];
  mis_exp_t mis_q [$];

  int checks   = 0;
  int failures = 0;
  int exp_branches = 0;
  int exp_mis_cnt  = 0;

  logic mon_en = 1'b0;
  logic lk_chk = 1'b0;
  logic rv_d   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rv_d <= res_valid && !rst;

  // Monitor: lookup outputs and the registered mispredict response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (lk_chk) begin
        if (lk_q.size() == 0) begin
          check("lookup_queue_underflow", 32'd1, 32'd0);
        end else begin
          lk_exp_t e;
          e = lk_q.pop_front();
          check("lookup_pc_echo", lookup_pc, e.pc);
          check("pred_hit", 32'(pred_hit), 32'(e.hit));
          check("pred_taken", 32'(pred_taken), 32'(e.taken));
          check("pred_target", pred_target, e.target);
        end
      end
      if (rv_d) begin
        if (mis_q.size() == 0) begin
          check("mispredict_queue_underflow", 32'd1, 32'd0);
        end else begin
          mis_exp_t m;
          m = mis_q.pop_front();
          check("mispredict", 32'(mispredict), 32'(m.mis));
          if (m.mis) check("redirect_pc", redirect_pc, m.redir);
        end
      end else begin
        check("mispredict_idle", 32'(mispredict), 32'd0);
      end
    end
  end

  // One cycle of stimulus plus its hand-computed expectations.
  task automatic step(input logic r,
                      input logic [31:0] lpc, input logic chk,
                      input logic eh, input logic et, input logic [31:0] etgt,
                      input logic rv, input logic [31:0] rpc, input logic rtk,
                      input logic [31:0] rtgt, input logic rptk, input logic [31:0] rptgt,
                      input logic emis, input logic [31:0] eredir);
    lk_exp_t  le;
    mis_exp_t me;
    @(posedge clk);
    #1;
    rst             = r;
    lookup_pc       = lpc;
    res_valid       = rv;
    res_pc          = rpc;
    res_taken       = rtk;
    res_target      = rtgt;
    res_pred_taken  = rptk;
    res_pred_target = rptgt;
    lk_chk          = chk && !r;
    if (r) begin
      exp_branches = 0;
      exp_mis_cnt  = 0;
    end else begin
      if (chk) begin
        le.pc = lpc; le.hit = eh; le.taken = et; le.target = etgt;
        lk_q.push_back(le);
      end
      if (rv) begin
        me.mis = emis; me.redir = eredir;
        mis_q.push_back(me);
        exp_branches++;
        if (emis) exp_mis_cnt++;
      end
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    step(1'b0, lpc, 1'b0, 1'b0, 1'b0, 32'h0,
         1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; lookup_pc = 32'h100; res_valid = 1'b0; res_pc = '0;
    res_taken = 1'b0; res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check("reset_redirect_pc", redirect_pc, 32'h0);
`ifdef BP_STATS_EN
    check("reset_stat_branches", stat_branches, 32'h0);
    check("reset_stat_mispredicts", stat_mispredicts, 32'h0);
`endif
    //    rst  lookup     chk eh  et  etgt          rv  rpc          rtk rtgt          rptk rptgt         emis eredir
    step(1'b0, 32'h100,   1, 0, 0, 32'h104,       0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1'b0, 32'h100,   1, 0, 0, 32'h104,       1, 32'h100,      1, 32'h200,       0, 32'h104,       1, 32'h200);
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h100,      1, 32'h200,       1, 32'h200,       0, 32'h0);
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h100,      1, 32'h200,       1, 32'h200,       0, 32'h0);
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h100,      0, 32'h0,         1, 32'h200,       1, 32'h104);
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h100,      0, 32'h0,         1, 32'h200,       1, 32'h104);
    step(1'b0, 32'h100,   1, 1, 0, 32'h104,       1, 32'h100,      0, 32'h0,         1, 32'h200,       1, 32'h104);
    step(1'b0, 32'h100,   1, 1, 0, 32'h104,       1, 32'h100,      0, 32'h0,         0, 32'h104,       0, 32'h0);
    step(1'b0, 32'h100,   1, 1, 0, 32'h104,       1, 32'h100,      1, 32'h200,       0, 32'h104,       1, 32'h200);
    // counter now 01: same-cycle taken resolve is invisible until the next cycle
    step(1'b0, 32'h100,   1, 1, 0, 32'h104,       1, 32'h100,      1, 32'h200,       0, 32'h104,       1, 32'h200);
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h100,      1, 32'h200,       1, 32'h240,       1, 32'h200);
    // alias at index 0 replaces the 0x100 BTB entry
    step(1'b0, 32'h100,   1, 1, 1, 32'h200,       1, 32'h200,      1, 32'h300,       0, 32'h204,       1, 32'h300);
    step(1'b0, 32'h100,   1, 0, 0, 32'h104,       0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1'b0, 32'h200,   1, 1, 1, 32'h300,       1, 32'h200,      0, 32'h0,         1, 32'h300,       1, 32'h204);
    step(1'b0, 32'h200,   1, 1, 1, 32'h300,       0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1'b0, 32'h104,   1, 0, 0, 32'h108,       0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1'b0, 32'hFFFFFFFC, 1, 0, 0, 32'h0,      0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    // reset with a concurrent resolve: the update must be dropped
    step(1'b1, 32'h104,   0, 0, 0, 32'h0,         1, 32'h104,      1, 32'h500,       0, 32'h108,       0, 32'h0);
    step(1'b0, 32'h200,   1, 0, 0, 32'h204,       0, 32'h0,        0, 32'h0,         0, 32'h0,         0, 32'h0);
    step(1'b0, 32'h104,   1, 0, 0, 32'h108,       1, 32'h104,      1, 32'h500,       0, 32'h108,       1, 32'h500);
    step(1'b0, 32'h104,   1, 1, 1, 32'h500,       1, 32'h104,      0, 32'h0,         1, 32'h500,       1, 32'h108);
    step(1'b0, 32'h104,   1, 1, 0, 32'h108,       1, 32'h104,      0, 32'h0,         0, 32'h108,       0, 32'h0);
    step(1'b0, 32'h104,   1, 1, 0, 32'h108,       1, 32'h104,      1, 32'h500,       1, 32'h500,       0, 32'h0);
    step(1'b0, 32'h104,   1, 1, 0, 32'h108,       1, 32'h104,      1, 32'h500,       0, 32'h108,       1, 32'h500);
    idle(32'h0);
    idle(32'h0);
    idle(32'h0);
    #1;
    check("lookup_queue_drained", 32'(lk_q.size()), 32'd0);
    check("mispredict_queue_drained", 32'(mis_q.size()), 32'd0);
`ifdef BP_STATS_EN
    check("stat_branches", stat_branches, 32'(exp_branches));
    check("stat_mispredicts", stat_mispredicts, 32'(exp_mis_cnt));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
